control_multicycle_fsm: RTL and testbench
=========================================

# control_multicycle_fsm

Multicycle main controller for the team's ARM-subset datapath. It replaces the single-cycle combinational main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds a memory-ready handshake, an illegal-opcode flag and a retired-instruction counter. It sits between the instruction register (op/funct fields) and the shared ALU/memory/register-file datapath; the ALU decoder and condition logic stay external.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter
- WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  2  instruction op field: 00 data-proc, 01 memory, 10 branch, 11 illegal
- funct5  in  1  immediate bit (I)
- funct0  in  1  load bit (L): 1 load, 0 store
- mem_ready  in  1  memory completes the current access this cycle
- pcupdate  out  1  PC write enable
- irwrite  out  1  instruction register write enable
- regw  out  1  register-file write enable
- memw  out  1  data memory write request
- branch  out  1  branch cycle, qualified externally by condition logic
- adrsrc  out  1  0 = PC, 1 = ALUOut as memory address
- alusrca  out  1  0 = Rn, 1 = PC
- alusrcb  out  2  00 register, 01 extended imm, 10 constant 4
- resultsrc  out  2  00 ALUOut, 01 read data, 10 ALU result
- immsrc  out  2  00 data-proc imm, 01 memory offset, 10 branch offset
- regsrc  out  2  register-read select, same encoding as the single-cycle decoder
- aluop  out  1  1 = ALU decoder uses funct, 0 = add
- illegal  out  1  one-cycle pulse on op 11 at DECODE
- state_o  out  4  current state, debug
- instr_cnt  out  CNT_W  retired-instruction count

## Operation
- Moore outputs decoded from the state register. Any signal not listed for a state is 0.
- FETCH: alusrca=1, alusrcb=10, resultsrc=10. irwrite and pcupdate are 1 only in the cycle mem_ready=1, which also moves to DECODE; otherwise stays in FETCH.
- DECODE: alusrca=1, alusrcb=10, resultsrc=10. Next state by op/funct5:
  - 00 with funct5=0 -> EXECR; 00 with funct5=1 -> EXECI
  - 01 -> MEMADR; 10 -> BRANCH
  - 11 -> FETCH with illegal=1
- EXECR: aluop=1 -> ALUWB. EXECI: alusrcb=01, immsrc=00, aluop=1 -> ALUWB.
- ALUWB: resultsrc=00, regw=1 -> FETCH.
- MEMADR: alusrcb=01, immsrc=01. funct0=1 -> MEMREAD; funct0=0 -> MEMWRITE.
- MEMREAD: adrsrc=1; holds until mem_ready, then -> MEMWB.
- MEMWB: resultsrc=01, regw=1 -> FETCH.
- MEMWRITE: adrsrc=1, memw=1, regsrc=10. memw stays high every waiting cycle; -> FETCH on mem_ready.
- BRANCH: alusrcb=01, immsrc=10, resultsrc=10, branch=1, regsrc=01 -> FETCH.
- instr_cnt increments by 1 on exit from ALUWB, MEMWB, MEMWRITE (with mem_ready) and BRANCH. Illegal ops do not count. Counter wraps modulo 2^CNT_W.
- op/funct are sampled only in DECODE and MEMADR; changes at other times have no effect.

## Timing
- Reset: on a clk edge with rst=1, state becomes FETCH and instr_cnt becomes 0. While rst=1, pcupdate, irwrite, regw, memw, branch and illegal are forced to 0 combinationally. The remaining outputs show FETCH values.
- Reset mid-operation (e.g. in MEMWRITE): memw drops in the same cycle rst rises, and the in-flight instruction is abandoned uncounted.
- Latency with mem_ready=1 (cycles, FETCH to FETCH): data-proc 4, load 5, store 4, branch 3, illegal 2. Each wait cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1.
- With WAIT_EN=0, mem_ready is ignored and latencies are fixed at the values above.
- Counter increment and state transition occur on the same edge.

## Structure
- A shared package `control_pkg` holds the state enum (4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9) and localparams for the op, alusrcb, resultsrc and immsrc encodings.
- One sub-module, `control_output_decode`: purely combinational, state in, control word out. The FSM keeps only the state register, next-state logic, reset gating and the counter.

## Test plan
- Reset: hold rst 2 cycles from any state -> state_o=0, all enables 0, instr_cnt=0. Release -> irwrite=1 on the first cycle.
- Data-proc immediate, op=00, funct5=1, ready=1 -> states 0,1,7,8,0. regw=1 only in state 8; instr_cnt=1 after 4 cycles.
- Load with 2 wait cycles in MEMREAD, op=01, funct0=1 -> 3 cycles in state 3, then MEMWB with resultsrc=01 and regw=1; total 7 cycles.
- Store with rst asserted on the 2nd MEMWRITE wait cycle -> memw=0 that cycle, state FETCH next, instr_cnt unchanged.
- op=11 -> illegal=1 for exactly one cycle in DECODE, back to FETCH, instr_cnt unchanged.
- CNT_W=4: retire 17 branches -> instr_cnt=1 (wrap). With WAIT_EN=0 and mem_ready=0, a branch still completes in 3 cycles.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle main controller.
// State enum, datapath select codes and the control word bundle.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] REGSRC_DEF = 2'b00;
  localparam logic [1:0] REGSRC_BR  = 2'b01;
  localparam logic [1:0] REGSRC_ST  = 2'b10;

  typedef struct packed {
    logic       pcupdate;
    logic       irwrite;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic       aluop;
  } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// Moore control word for each controller state.
// FETCH fetch enables are raw here; the FSM qualifies them.
module control_output_decode
  import control_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  // state -> control word, everything unlisted stays 0
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.alusrca   = 1'b1;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.resultsrc = RES_ALURES;
        ctrl_o.irwrite   = 1'b1;
        ctrl_o.pcupdate  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alusrca   = 1'b1;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.resultsrc = RES_ALURES;
      end
      S_EXECR: begin
        ctrl_o.aluop = 1'b1;
      end
      S_EXECI: begin
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.immsrc  = IMM_DP;
        ctrl_o.aluop   = 1'b1;
      end
      S_ALUWB: begin
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.regw      = 1'b1;
      end
      S_MEMADR: begin
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.immsrc  = IMM_MEM;
      end
      S_MEMREAD: begin
        ctrl_o.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.resultsrc = RES_RDATA;
        ctrl_o.regw      = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.adrsrc = 1'b1;
        ctrl_o.memw   = 1'b1;
        ctrl_o.regsrc = REGSRC_ST;
      end
      S_BRANCH: begin
        ctrl_o.alusrcb   = SRCB_IMM;
        ctrl_o.immsrc    = IMM_BR;
        ctrl_o.resultsrc = RES_ALURES;
        ctrl_o.branch    = 1'b1;
        ctrl_o.regsrc    = REGSRC_BR;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_multicycle_fsm.sv
// Multicycle main controller: state register, sequencing,
// reset gating of enables and retired-instruction counter.
module control_multicycle_fsm
  import control_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             funct5,
  input  logic             funct0,
  input  logic             mem_ready,
  output logic             pcupdate,
  output logic             irwrite,
  output logic             regw,
  output logic             memw,
  output logic             branch,
  output logic             adrsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       resultsrc,
  output logic [1:0]       immsrc,
  output logic [1:0]       regsrc,
  output logic             aluop,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q, state_d, dec_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready, retire, run;
  ctrl_t            ctrl;

  assign ready = WAIT_EN ? mem_ready : 1'b1;
  assign run   = ~rst;

  // next state and retire strobe
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:
        if (ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_DP:   state_d = funct5 ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXECR, S_EXECI:
        state_d = S_ALUWB;
      S_MEMADR:
        state_d = funct0 ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:
        if (ready) state_d = S_MEMWB;
      S_MEMWRITE:
        if (ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      S_ALUWB, S_MEMWB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};

  // state and counter registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // during reset the selects show FETCH, enables are held low
  assign dec_state = rst ? S_FETCH : state_q;

  control_output_decode u_dec (
    .state_i (dec_state),
    .ctrl_o  (ctrl)
  );

  assign pcupdate  = ctrl.pcupdate & ready & run;
  assign irwrite   = ctrl.irwrite & ready & run;
  assign regw      = ctrl.regw & run;
  assign memw      = ctrl.memw & run;
  assign branch    = ctrl.branch & run;
  assign adrsrc    = ctrl.adrsrc;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign resultsrc = ctrl.resultsrc;
  assign immsrc    = ctrl.immsrc;
  assign regsrc    = ctrl.regsrc;
  assign aluop     = ctrl.aluop;
  assign illegal   = (state_q == S_DECODE) & (op == OP_ILL) & run;
  assign state_o   = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_multicycle_fsm.sv
// Bench for control_multicycle_fsm: per-instruction cycle
// sequences from the instruction class and wait counts.
module tb_control_multicycle_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op = 2'b00;
  logic        funct5 = 1'b0, funct0 = 1'b0, mem_ready = 1'b1;
  logic        pcupdate, irwrite, regw, memw, branch, adrsrc;
  logic        alusrca, aluop, illegal;
  logic [1:0]  alusrcb, resultsrc, immsrc, regsrc;
  logic [3:0]  state_o;
  logic [15:0] instr_cnt;

  logic        nw_rst = 1'b1;
  logic [1:0]  nw_op = 2'b00;
  logic        nw_f5 = 1'b0, nw_f0 = 1'b0, nw_ready = 1'b0;
  logic        nw_pcu, nw_irw, nw_regw, nw_memw, nw_br, nw_adr;
  logic        nw_sa, nw_aop, nw_ill;
  logic [1:0]  nw_sb, nw_rs, nw_im, nw_rg;
  logic [3:0]  nw_state;
  logic [3:0]  nw_cnt;

  logic [16:0] obs, nw_obs;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  control_multicycle_fsm u_dut (
    .clk(clk), .rst(rst), .op(op), .funct5(funct5),
    .funct0(funct0), .mem_ready(mem_ready),
    .pcupdate(pcupdate), .irwrite(irwrite), .regw(regw),
    .memw(memw), .branch(branch), .adrsrc(adrsrc),
    .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .immsrc(immsrc),
    .regsrc(regsrc), .aluop(aluop), .illegal(illegal),
    .state_o(state_o), .instr_cnt(instr_cnt)
  );

  control_multicycle_fsm #(.CNT_W(4), .WAIT_EN(1'b0)) u_nw (
    .clk(clk), .rst(nw_rst), .op(nw_op), .funct5(nw_f5),
    .funct0(nw_f0), .mem_ready(nw_ready),
    .pcupdate(nw_pcu), .irwrite(nw_irw), .regw(nw_regw),
    .memw(nw_memw), .branch(nw_br), .adrsrc(nw_adr),
    .alusrca(nw_sa), .alusrcb(nw_sb),
    .resultsrc(nw_rs), .immsrc(nw_im),
    .regsrc(nw_rg), .aluop(nw_aop), .illegal(nw_ill),
    .state_o(nw_state), .instr_cnt(nw_cnt)
  );

  assign obs = {pcupdate, irwrite, regw, memw, branch,
                illegal, adrsrc, alusrca, alusrcb, resultsrc,
                immsrc, regsrc, aluop};
  assign nw_obs = {nw_pcu, nw_irw, nw_regw, nw_memw, nw_br,
                   nw_ill, nw_adr, nw_sa, nw_sb, nw_rs,
                   nw_im, nw_rg, nw_aop};

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // control word table for a state, in obs bit order
  function automatic logic [16:0] exp_ctl(int st, bit rdy,
                                          bit ill, bit r);
    logic pc, ir, rw, mw, br, il, ad, sa, ao;
    logic [1:0] sb, rs, im, rg;
    int s;
    s = r ? 0 : st;
    {pc, ir, rw, mw, br, il, ad, sa, ao} = '0;
    {sb, rs, im, rg} = '0;
    case (s)
      0: begin sa = 1; sb = 2; rs = 2; pc = rdy; ir = rdy; end
      1: begin sa = 1; sb = 2; rs = 2; il = ill; end
      2: begin sb = 1; im = 1; end
      3: ad = 1;
      4: begin rs = 1; rw = 1; end
      5: begin ad = 1; mw = 1; rg = 2; end
      6: ao = 1;
      7: begin sb = 1; im = 0; ao = 1; end
      8: begin rs = 0; rw = 1; end
      9: begin sb = 1; im = 2; rs = 2; br = 1; rg = 1; end
      default: ;
    endcase
    if (r) {pc, ir, rw, mw, br, il} = '0;
    return {pc, ir, rw, mw, br, il, ad, sa, sb, rs, im, rg, ao};
  endfunction

  task automatic cyc(int st, bit rdy, bit ill, bit r,
                     bit chk_st);
    @(negedge clk);
    if (chk_st) check("state", state_o, st);
    check("ctl", obs, exp_ctl(st, rdy, ill, r));
    check("cnt", instr_cnt, exp_cnt & 32'hFFFF);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n, bit rdy);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      mem_ready = rdy;
      {op, funct5, funct0} = 4'($urandom);
      cyc(0, rdy, 1'b0, 1'b1, i > 0);
      exp_cnt = 0;
    end
    rst = 1'b0;
  endtask

  // kind: 0 dp-reg, 1 dp-imm, 2 load, 3 store, 4 branch, 5 illegal
  task automatic run_instr(int kind, int fw, int mw);
    int sq[$];
    bit rq[$];
    logic [1:0] kop;
    kop = (kind < 2) ? 2'b00 : (kind < 4) ? 2'b01 :
          (kind == 4) ? 2'b10 : 2'b11;
    repeat (fw) begin sq.push_back(0); rq.push_back(0); end
    sq.push_back(0); rq.push_back(1);
    sq.push_back(1); rq.push_back(1'($urandom));
    case (kind)
      0, 1: begin
        sq.push_back(kind == 0 ? 6 : 7); rq.push_back(1'($urandom));
        sq.push_back(8); rq.push_back(1'($urandom));
      end
      2: begin
        sq.push_back(2); rq.push_back(1'($urandom));
        repeat (mw) begin sq.push_back(3); rq.push_back(0); end
        sq.push_back(3); rq.push_back(1);
        sq.push_back(4); rq.push_back(1'($urandom));
      end
      3: begin
        sq.push_back(2); rq.push_back(1'($urandom));
        repeat (mw) begin sq.push_back(5); rq.push_back(0); end
        sq.push_back(5); rq.push_back(1);
      end
      4: begin sq.push_back(9); rq.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      rst = 1'b0;
      mem_ready = rq[i];
      {op, funct5, funct0} = 4'($urandom);
      if (sq[i] == 1) begin op = kop; funct5 = (kind == 1); end
      if (sq[i] == 2) funct0 = (kind == 2);
      cyc(sq[i], rq[i], (sq[i] == 1) && (kind == 5), 1'b0, 1'b1);
    end
    if (kind != 5) exp_cnt++;
  endtask

  task automatic nw_cyc(int st);
    @(negedge clk);
    check("nw_state", nw_state, st);
    check("nw_ctl", nw_obs, exp_ctl(st, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(2, 1'b1);

    run_instr(1, 0, 0);
    run_instr(2, 0, 2);
    run_instr(5, 0, 0);
    run_instr(0, 1, 0);
    run_instr(3, 0, 1);
    run_instr(4, 2, 0);

    // store abandoned by reset on its second wait cycle
    rst = 1'b0; mem_ready = 1'b1; op = 2'($urandom);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1);
    op = 2'b01; mem_ready = 1'($urandom);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
    funct0 = 1'b0; op = 2'($urandom);
    cyc(2, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_ready = 1'b0;
    cyc(5, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(2, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 5), $urandom_range(0, 2),
                $urandom_range(0, 3));
    do_reset(2, 1'b1);

    // no-wait instance: branches ignore mem_ready, counter wraps
    rst = 1'b1;
    nw_rst = 1'b1;
    @(posedge clk);
    #1;
    nw_rst = 1'b0;
    nw_ready = 1'b0;
    for (int b = 0; b < 17; b++) begin
      nw_op = 2'($urandom);
      nw_cyc(0);
      nw_op = 2'b10;
      nw_cyc(1);
      nw_op = 2'($urandom);
      nw_cyc(9);
    end
    @(negedge clk);
    check("nw_wrap", nw_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
